leaf_stream_bridge: RTL and testbench
=====================================

// Module: leaf_stream_bridge
// PURPOSE
// Parametrised buffer between a leaf_interface port bundle and an HLS operator's AXI-stream ports.
// Provides NUM_IN ingress channels (interface->user) and NUM_OUT egress channels (user->interface).
// Each channel has its own DEPTH-entry FIFO, so interface and operator back-pressure are decoupled.
// Adds start gating, per-channel saturating beat counters and an idle flag.
// PARAMETERS
// PAYLOAD_BITS  32  data width per channel
// NUM_IN        3   ingress channel count (1..15)
// NUM_OUT       3   egress channel count (1..15)
// DEPTH         4   FIFO entries per channel; power of two, >=2; AW=$clog2(DEPTH)
// CNT_BITS      16  width of each beat counter
// PORTS
// ap_clk          in   1                  clock, all logic rising-edge
// ap_rst_n        in   1                  asynchronous active-low reset
// ap_start        in   1                  start request; sampled every cycle
// run             out  1                  start latched; user side enabled
// idle            out  1                  run=1 and every FIFO empty
// if_in_data      in   NUM_IN*PB          ingress data from interface; ch k at [k*PB+:PB]
// if_in_vld       in   NUM_IN             ingress valid, per channel
// if_in_ack       out  NUM_IN             ingress ready, per channel (=FIFO not full)
// m_tdata         out  NUM_IN*PB          to operator Input_k TDATA
// m_tvalid        out  NUM_IN             to operator TVALID
// m_tready        in   NUM_IN             from operator TREADY
// s_tdata         in   NUM_OUT*PB         from operator Output_k TDATA
// s_tvalid        in   NUM_OUT            from operator TVALID
// s_tready        out  NUM_OUT            to operator TREADY
// if_out_data     out  NUM_OUT*PB         egress data to interface
// if_out_vld      out  NUM_OUT            egress valid
// if_out_ack      in   NUM_OUT            egress ready from interface
// in_beat_cnt     out  NUM_IN*CNT_BITS    beats popped to operator, per ingress channel
// out_beat_cnt    out  NUM_OUT*CNT_BITS   beats pushed from operator, per egress channel
// BEHAVIOUR
// - Transfer on any edge = valid & ready in the same cycle. Both sides use this rule.
// - Reset (async assert, sync release): all FIFO pointers and counts clear; run=0; counters=0.
//   All vld/tvalid/ack/tready outputs are 0. FIFO contents are discarded; in-flight beats are lost.
// - run: set on the first cycle ap_start=1 and held until reset. ap_start deassertion has no effect.
// - FIFO per channel: wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. count is AW+1 bits.
//   full = (count==DEPTH); empty = (count==0). Push+pop in the same cycle leaves count unchanged.
// - Ready outputs derive from count only. There is no combinational path from any ready input
//   to any ready output.
// - Ingress: if_in_ack[k] = !full. Push happens independent of run, so the interface may prefill.
//   m_tvalid[k] = run & !empty. m_tdata[k] = mem[rd_ptr].
//   A pop occurs when m_tvalid & m_tready.
// - Egress: s_tready[k] = run & !full. if_out_vld[k] = !empty, so it drains even if run
//   would later matter. if_out_data[k] = mem[rd_ptr].
// - Latency: a beat pushed at edge N is visible at the far side after edge N (1 cycle).
//   Full throughput is 1 beat/cycle/channel when both sides are ready.
// - Data hold: while valid=1 and ready=0, data and valid stay stable.
// - Counters: in_beat_cnt[k] increments on each m_tvalid&m_tready. out_beat_cnt[k] increments
//   on each s_tvalid&s_tready. Both saturate at 2^CNT_BITS-1 and never wrap.
// - idle = run & all counts zero. idle is 0 before run.
// - A channel whose valid is held 0 never affects any other channel.
// TESTING
// - Reset: ap_rst_n=0 mid-stream with FIFO count=3 -> all valid outputs and counters 0 immediately.
//   Acks go 1 one cycle after release.
// - Prefill gating: run=0, push 4 words 0xA0..0xA3 on ch0 -> if_in_ack[0]=0 after 4th beat;
//   m_tvalid=0. Pulse ap_start -> m_tvalid=1 next cycle; words 0xA0..0xA3 emerge in order.
// - Throughput: run=1, continuous 100 beats on all 3 ingress channels with m_tready=1 -> 1 beat/cycle.
//   in_beat_cnt=100 each; order preserved.
// - Back-pressure/wrap: egress ch2, if_out_ack toggles 1/0, 37 beats -> no loss or duplication;
//   s_tready low only when count=DEPTH; pointers wrap 9+ times.
// - Simultaneous push/pop at count=DEPTH-1 and count=1 -> count unchanged; ack/valid stay 1.
// - Saturation: CNT_BITS=4, send 20 beats -> counter reads 15 and holds at 15.

Source files
------------

// File: rtl/leaf_stream_bridge_if.sv
// Stream bundle between the leaf interface, the bridge and the HLS operator.
// master = environment side (leaf interface + operator), slave = the bridge.
interface leaf_stream_bridge_if #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_IN       = 3,
    parameter int NUM_OUT      = 3
);
    logic [NUM_IN*PAYLOAD_BITS-1:0]  if_in_data;
    logic [NUM_IN-1:0]               if_in_vld;
    logic [NUM_IN-1:0]               if_in_ack;
    logic [NUM_IN*PAYLOAD_BITS-1:0]  m_tdata;
    logic [NUM_IN-1:0]               m_tvalid;
    logic [NUM_IN-1:0]               m_tready;
    logic [NUM_OUT*PAYLOAD_BITS-1:0] s_tdata;
    logic [NUM_OUT-1:0]              s_tvalid;
    logic [NUM_OUT-1:0]              s_tready;
    logic [NUM_OUT*PAYLOAD_BITS-1:0] if_out_data;
    logic [NUM_OUT-1:0]              if_out_vld;
    logic [NUM_OUT-1:0]              if_out_ack;

    modport slave (
        input  if_in_data, if_in_vld, m_tready, s_tdata, s_tvalid, if_out_ack,
        output if_in_ack, m_tdata, m_tvalid, s_tready, if_out_data, if_out_vld
    );

    modport master (
        output if_in_data, if_in_vld, m_tready, s_tdata, s_tvalid, if_out_ack,
        input  if_in_ack, m_tdata, m_tvalid, s_tready, if_out_data, if_out_vld
    );
endinterface

// File: rtl/leaf_stream_bridge.sv
// Per-channel DEPTH-entry FIFO bridge between leaf_interface ports and HLS AXI-stream ports.
// Latency: a beat pushed at edge N is visible on the far side after edge N; 1 beat/cycle/channel.
// Backpressure: each ready is "FIFO not full" from the registered count; operator side gated by run.
module leaf_stream_bridge #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_IN       = 3,
    parameter int NUM_OUT      = 3,
    parameter int DEPTH        = 4,
    parameter int CNT_BITS     = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        run,
    output logic                        idle,
    leaf_stream_bridge_if.slave         bus,
    output logic [NUM_IN*CNT_BITS-1:0]  in_beat_cnt,
    output logic [NUM_OUT*CNT_BITS-1:0] out_beat_cnt
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          NCH      = NUM_IN + NUM_OUT;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic                    rst_done;
    logic [NCH-1:0]          push;
    logic [NCH-1:0]          pop;
    logic [NCH-1:0]          full;
    logic [NCH-1:0]          empty;
    logic [PAYLOAD_BITS-1:0] wr_dat [NCH];
    logic [PAYLOAD_BITS-1:0] rd_dat [NCH];

    // rst_done holds the interface acks low for the first cycle after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            run      <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (ap_start) begin
                run <= 1'b1;
            end
        end
    end

    assign idle = run & (&empty);

    // Channels 0..NUM_IN-1 are ingress, NUM_IN..NCH-1 egress; FIFO and counter logic is shared.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PAYLOAD_BITS-1:0] mem [DEPTH];
        logic [AW-1:0]           wr_ptr;
        logic [AW-1:0]           rd_ptr;
        logic [AW:0]             count;
        logic [CNT_BITS-1:0]     cnt;
        logic                    beat;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[c]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push[c] && !pop[c]) begin
                    count <= count + (AW+1)'(1);
                end else if (!push[c] && pop[c]) begin
                    count <= count - (AW+1)'(1);
                end
            end
        end

        always_ff @(posedge ap_clk) begin
            if (push[c]) begin
                mem[wr_ptr] <= wr_dat[c];
            end
        end

        assign rd_dat[c] = mem[rd_ptr];
        assign full[c]   = (count == FULL_CNT);
        assign empty[c]  = (count == '0);

        // Ingress counts beats delivered to the operator, egress counts beats taken from it.
        assign beat = (c < NUM_IN) ? pop[c] : push[c];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                cnt <= '0;
            end else if (beat && (cnt != '1)) begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end

        if (c < NUM_IN) begin : g_icnt
            assign in_beat_cnt[c*CNT_BITS +: CNT_BITS] = cnt;
        end else begin : g_ocnt
            assign out_beat_cnt[(c-NUM_IN)*CNT_BITS +: CNT_BITS] = cnt;
        end
    end

    // Ingress: prefill is allowed before run; only the operator side waits for start.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        assign wr_dat[k]                                 = bus.if_in_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign push[k]                                   = bus.if_in_vld[k] & rst_done & ~full[k];
        assign pop[k]                                    = run & ~empty[k] & bus.m_tready[k];
        assign bus.if_in_ack[k]                          = rst_done & ~full[k];
        assign bus.m_tvalid[k]                           = run & ~empty[k];
        assign bus.m_tdata[k*PAYLOAD_BITS +: PAYLOAD_BITS] = rd_dat[k];
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign wr_dat[NUM_IN+k]                              = bus.s_tdata[k*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign push[NUM_IN+k]                                = bus.s_tvalid[k] & run & ~full[NUM_IN+k];
        assign pop[NUM_IN+k]                                 = ~empty[NUM_IN+k] & bus.if_out_ack[k];
        assign bus.s_tready[k]                               = run & ~full[NUM_IN+k];
        assign bus.if_out_vld[k]                             = ~empty[NUM_IN+k];
        assign bus.if_out_data[k*PAYLOAD_BITS +: PAYLOAD_BITS] = rd_dat[NUM_IN+k];
    end
endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Directed bench for leaf_stream_bridge: queue-based reference model checked every cycle,
// plus literal expectations for prefill, reset, throughput, back-pressure and saturation.
module tb_leaf_stream_bridge;
    localparam int PB    = 32;
    localparam int NI    = 3;
    localparam int NO    = 3;
    localparam int DEPTH = 4;
    localparam int CB    = 16;

    logic             clk;
    logic             rst_n;
    logic             ap_start;
    logic             run, idle, run2, idle2;
    logic [NI*CB-1:0] in_cnt;
    logic [NO*CB-1:0] out_cnt;
    logic [3:0]       in_cnt2, out_cnt2;

    leaf_stream_bridge_if #(.PAYLOAD_BITS(PB), .NUM_IN(NI), .NUM_OUT(NO)) bus ();
    leaf_stream_bridge_if #(.PAYLOAD_BITS(PB), .NUM_IN(1),  .NUM_OUT(1))  bus2 ();

    leaf_stream_bridge #(.PAYLOAD_BITS(PB), .NUM_IN(NI), .NUM_OUT(NO), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .run(run), .idle(idle),
        .bus(bus), .in_beat_cnt(in_cnt), .out_beat_cnt(out_cnt)
    );

    leaf_stream_bridge #(.PAYLOAD_BITS(PB), .NUM_IN(1), .NUM_OUT(1), .DEPTH(DEPTH), .CNT_BITS(4)) dut_sat (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .run(run2), .idle(idle2),
        .bus(bus2), .in_beat_cnt(in_cnt2), .out_beat_cnt(out_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, state as seen after the next rising edge.
    logic [PB-1:0] qi [NI][$];
    logic [PB-1:0] qo [NO][$];
    int            icnt_m [NI];
    int            ocnt_m [NO];
    bit            run_m, rdone_m;

    always @(negedge clk) begin
        bit ack_e, vld_e, idle_e;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin qi[k].delete(); icnt_m[k] = 0; end
            for (int k = 0; k < NO; k++) begin qo[k].delete(); ocnt_m[k] = 0; end
            run_m   = 1'b0;
            rdone_m = 1'b0;
            chk("rst_run", run, 0);
            chk("rst_idle", idle, 0);
            chk("rst_in_ack", bus.if_in_ack, 0);
            chk("rst_m_tvalid", bus.m_tvalid, 0);
            chk("rst_s_tready", bus.s_tready, 0);
            chk("rst_out_vld", bus.if_out_vld, 0);
            chk("rst_in_cnt", in_cnt, 0);
            chk("rst_out_cnt", out_cnt, 0);
        end else begin
            idle_e = run_m;
            for (int k = 0; k < NI; k++) if (qi[k].size() != 0) idle_e = 1'b0;
            for (int k = 0; k < NO; k++) if (qo[k].size() != 0) idle_e = 1'b0;
            chk("run", run, run_m);
            chk("idle", idle, idle_e);
            for (int k = 0; k < NI; k++) begin
                ack_e = rdone_m && (qi[k].size() < DEPTH);
                vld_e = run_m && (qi[k].size() > 0);
                chk($sformatf("in_ack%0d", k), bus.if_in_ack[k], ack_e);
                chk($sformatf("m_tvalid%0d", k), bus.m_tvalid[k], vld_e);
                if (vld_e) chk($sformatf("m_tdata%0d", k), bus.m_tdata[k*PB +: PB], qi[k][0]);
                chk($sformatf("in_cnt%0d", k), in_cnt[k*CB +: CB], icnt_m[k]);
                if (vld_e && bus.m_tready[k]) begin
                    void'(qi[k].pop_front());
                    if (icnt_m[k] < (2**CB) - 1) icnt_m[k]++;
                end
                if (ack_e && bus.if_in_vld[k]) qi[k].push_back(bus.if_in_data[k*PB +: PB]);
            end
            for (int k = 0; k < NO; k++) begin
                ack_e = run_m && (qo[k].size() < DEPTH);
                vld_e = (qo[k].size() > 0);
                chk($sformatf("s_tready%0d", k), bus.s_tready[k], ack_e);
                chk($sformatf("out_vld%0d", k), bus.if_out_vld[k], vld_e);
                if (vld_e) chk($sformatf("out_data%0d", k), bus.if_out_data[k*PB +: PB], qo[k][0]);
                chk($sformatf("out_cnt%0d", k), out_cnt[k*CB +: CB], ocnt_m[k]);
                if (vld_e && bus.if_out_ack[k]) void'(qo[k].pop_front());
                if (ack_e && bus.s_tvalid[k]) begin
                    qo[k].push_back(bus.s_tdata[k*PB +: PB]);
                    if (ocnt_m[k] < (2**CB) - 1) ocnt_m[k]++;
                end
            end
            if (ap_start) run_m = 1'b1;
            rdone_m = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, got;
        rst_n = 1'b0;
        ap_start = 1'b0;
        bus.if_in_data = '0;  bus.if_in_vld = '0;  bus.m_tready = '0;
        bus.s_tdata = '0;     bus.s_tvalid = '0;   bus.if_out_ack = '0;
        bus2.if_in_data = '0; bus2.if_in_vld = '0; bus2.m_tready = '0;
        bus2.s_tdata = '0;    bus2.s_tvalid = '0;  bus2.if_out_ack = '0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("ack_at_release", bus.if_in_ack, 3'b000);
        step();
        chk("ack_after_release", bus.if_in_ack, 3'b111);

        // Prefill before start: ch0 fills, operator side stays quiet.
        for (int i = 0; i < 4; i++) begin
            bus.if_in_vld[0] = 1'b1;
            bus.if_in_data[0 +: PB] = 32'hA0 + i;
            step();
        end
        bus.if_in_vld[0] = 1'b0;
        chk("prefill_ack", bus.if_in_ack[0], 0);
        chk("prefill_tvalid", bus.m_tvalid[0], 0);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        chk("start_tvalid", bus.m_tvalid[0], 1);
        bus.m_tready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("prefill_word", bus.m_tdata[0 +: PB], 32'hA0 + i);
            step();
        end
        bus.m_tready[0] = 1'b0;
        chk("prefill_drained", bus.m_tvalid[0], 0);
        chk("prefill_cnt", in_cnt[0 +: CB], 4);

        // Mid-stream reset with three beats held in ch1.
        for (int i = 0; i < 3; i++) begin
            bus.if_in_vld[1] = 1'b1;
            bus.if_in_data[PB +: PB] = 32'hC0 + i;
            step();
        end
        bus.if_in_vld[1] = 1'b0;
        chk("pre_reset_tvalid", bus.m_tvalid[1], 1);
        rst_n = 1'b0;
        #1;
        chk("reset_tvalid", bus.m_tvalid, 0);
        chk("reset_in_cnt", in_cnt, 0);
        chk("reset_ack", bus.if_in_ack, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reacked", bus.if_in_ack, 3'b111);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        chk("reset_discarded", bus.m_tvalid, 0);

        // Throughput: 100 beats on every ingress channel, operator always ready.
        bus.m_tready = '1;
        for (int i = 0; i < 100; i++) begin
            bus.if_in_vld = '1;
            for (int k = 0; k < NI; k++) bus.if_in_data[k*PB +: PB] = 32'(k*256 + i);
            step();
        end
        bus.if_in_vld = '0;
        step();
        step();
        for (int k = 0; k < NI; k++) chk($sformatf("thru_cnt%0d", k), in_cnt[k*CB +: CB], 100);

        // Egress ch2 under toggling interface ack: 37 beats, FIFO wraps 9+ times.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 400 && got < 37; c++) begin
            bus.s_tvalid[2] = (sent < 37);
            bus.s_tdata[2*PB +: PB] = 32'hE00 + sent;
            bus.if_out_ack[2] = (c[0] == 1'b0);
            @(negedge clk);
            if (bus.s_tvalid[2] && bus.s_tready[2]) sent++;
            if (bus.if_out_vld[2] && bus.if_out_ack[2]) begin
                chk("bp_order", bus.if_out_data[2*PB +: PB], 32'hE00 + got);
                got++;
            end
            step();
        end
        bus.s_tvalid = '0;
        bus.if_out_ack = '0;
        chk("bp_received", got, 37);
        chk("bp_out_cnt", out_cnt[2*CB +: CB], 37);

        // Simultaneous push/pop at count=DEPTH-1 and count=1 on ch0.
        bus.m_tready = '0;
        for (int i = 0; i < 3; i++) begin
            bus.if_in_vld[0] = 1'b1;
            bus.if_in_data[0 +: PB] = 32'hB0 + i;
            step();
        end
        bus.if_in_data[0 +: PB] = 32'hB3;
        bus.m_tready[0] = 1'b1;
        step();
        chk("pp3_ack", bus.if_in_ack[0], 1);
        chk("pp3_tvalid", bus.m_tvalid[0], 1);
        chk("pp3_data", bus.m_tdata[0 +: PB], 32'hB1);
        bus.if_in_data[0 +: PB] = 32'hB4;
        bus.m_tready[0] = 1'b0;
        step();
        chk("pp3_now_full", bus.if_in_ack[0], 0);
        bus.if_in_vld[0] = 1'b0;
        bus.m_tready[0] = 1'b1;
        repeat (3) step();
        chk("pp1_data", bus.m_tdata[0 +: PB], 32'hB4);
        bus.if_in_vld[0] = 1'b1;
        bus.if_in_data[0 +: PB] = 32'hB5;
        step();
        chk("pp1_tvalid", bus.m_tvalid[0], 1);
        chk("pp1_data2", bus.m_tdata[0 +: PB], 32'hB5);
        bus.if_in_vld[0] = 1'b0;
        step();
        chk("pp_empty", bus.m_tvalid[0], 0);
        chk("pp_idle", idle, 1);
        bus.m_tready = '0;

        // Saturation on the 4-bit counter instance.
        bus2.m_tready = 1'b1;
        bus2.if_out_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus2.if_in_vld = 1'b1;
            bus2.if_in_data = 32'(i);
            bus2.s_tvalid = 1'b1;
            bus2.s_tdata = 32'(i);
            step();
        end
        bus2.if_in_vld = 1'b0;
        bus2.s_tvalid = 1'b0;
        step();
        step();
        chk("sat_in", in_cnt2, 15);
        chk("sat_out", out_cnt2, 15);
        for (int i = 0; i < 5; i++) begin
            bus2.if_in_vld = 1'b1;
            bus2.s_tvalid = 1'b1;
            step();
        end
        bus2.if_in_vld = 1'b0;
        bus2.s_tvalid = 1'b0;
        step();
        step();
        chk("sat_hold_in", in_cnt2, 15);
        chk("sat_hold_out", out_cnt2, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
